// File: rtl/transmit_scheduler_pkg.sv
// Shared types and constants for the transmit slot scheduler.
// Beat layout: bit 8 marks end-of-frame, bits 7:0 carry the byte.
package transmit_scheduler_pkg;

    localparam int unsigned BEAT_WIDTH  = 9;
    localparam int unsigned EOF_BIT     = 8;
    localparam int unsigned COUNT_WIDTH = 16;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_TRANSFER = 2'd1,
        S_RELEASE  = 2'd2
    } state_t;

    // Index width that stays at least one bit wide for single-entry ranges.
    function automatic int unsigned width_of(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/transmit_slot_scheduler_picker.sv
// Rotated-priority search: first requester strictly after pointer, wrapping,
// with the pointer's own slot searched last.
module round_robin_picker
    import transmit_scheduler_pkg::*;
#(
    parameter int unsigned SLOTS = 4,
    parameter int unsigned PTR_W = width_of(SLOTS)
) (
    input  logic [SLOTS-1:0] request,
    input  logic [PTR_W-1:0] pointer,
    output logic             hit,
    output logic [PTR_W-1:0] index
);

    logic [PTR_W-1:0] candidate;

    // Walk offsets from farthest to nearest so the nearest hit wins.
    always_comb begin
        hit       = 1'b0;
        index     = '0;
        candidate = '0;
        for (int off = int'(SLOTS); off > 0; off--) begin
            candidate = PTR_W'((int'(pointer) + off) % int'(SLOTS));
            if (request[candidate]) begin
                hit   = 1'b1;
                index = candidate;
            end
        end
    end

endmodule

// File: rtl/transmit_slot_scheduler.sv
// Round-robin, frame-granular scheduler sharing one registered beat stream between SLOTS sources.
// Optional completed-frame counter enabled by TRANSMIT_SLOT_SCHEDULER_STATS_EN.
module transmit_slot_scheduler
    import transmit_scheduler_pkg::*;
#(
    parameter int unsigned SLOTS          = 4,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                              clock,
    input  logic                              reset_n,
    input  logic [SLOTS-1:0]                  request,
    input  logic [SLOTS-1:0][BEAT_WIDTH-1:0]  data,
    input  logic [SLOTS-1:0]                  data_valid,
    output logic [SLOTS-1:0]                  grant,
    output logic [SLOTS-1:0]                  pop,
    output logic [BEAT_WIDTH-1:0]             out_data,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic                              timeout_abort,
    output logic [COUNT_WIDTH-1:0]            frame_count
);

    localparam int unsigned        PTR_W     = width_of(SLOTS);
    localparam int unsigned        IDLE_W    = width_of(TIMEOUT_CYCLES);
    localparam logic [PTR_W-1:0]   PTR_RESET = PTR_W'(SLOTS - 1);
    localparam logic [IDLE_W-1:0]  IDLE_LAST = IDLE_W'(TIMEOUT_CYCLES - 1);

    state_t                 state_q, state_d;
    logic [SLOTS-1:0]       grant_q, grant_d;
    logic [PTR_W-1:0]       owner_q, owner_d;
    logic [PTR_W-1:0]       rr_q, rr_d;
    logic [IDLE_W-1:0]      idle_q, idle_d;
    logic [BEAT_WIDTH-1:0]  out_data_q, out_data_d;
    logic                   out_valid_q, out_valid_d;
    logic                   abort_q, abort_d;

    logic                   pick_hit;
    logic [PTR_W-1:0]       pick_index;
    logic                   can_take;
    logic                   accept;
    logic                   beat_eof;

    round_robin_picker #(
        .SLOTS (SLOTS),
        .PTR_W (PTR_W)
    ) u_picker (
        .request (request),
        .pointer (rr_q),
        .hit     (pick_hit),
        .index   (pick_index)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            grant_q     <= '0;
            owner_q     <= '0;
            rr_q        <= PTR_RESET;
            idle_q      <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            abort_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            owner_q     <= owner_d;
            rr_q        <= rr_d;
            idle_q      <= idle_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            abort_q     <= abort_d;
        end
    end

    // Next-state, output stage and combinational pop.
    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        owner_d     = owner_q;
        rr_d        = rr_q;
        idle_d      = idle_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        abort_d     = 1'b0;
        pop         = '0;
        accept      = 1'b0;
        can_take    = out_ready | ~out_valid_q;
        beat_eof    = data[owner_q][EOF_BIT];

        // Output register drains in every state unless refilled below.
        if (out_ready) begin
            out_valid_d = 1'b0;
        end

        unique case (state_q)
            S_IDLE: begin
                if (pick_hit) begin
                    grant_d = SLOTS'(1) << pick_index;
                    owner_d = pick_index;
                    idle_d  = '0;
                    state_d = S_TRANSFER;
                end
            end

            S_TRANSFER: begin
                accept       = data_valid[owner_q] & can_take;
                pop[owner_q] = accept;
                if (accept) begin
                    out_data_d  = data[owner_q];
                    out_valid_d = 1'b1;
                    idle_d      = '0;
                end else if (can_take) begin
                    idle_d = IDLE_W'(idle_q + 1'b1);
                end

                // A dropped request ends the grant quietly; only a live stall aborts.
                if ((accept && beat_eof) || !request[owner_q]) begin
                    grant_d = '0;
                    rr_d    = (SLOTS > 1) ? owner_q : '0;
                    state_d = S_RELEASE;
                end else if (!accept && can_take && idle_q == IDLE_LAST) begin
                    abort_d = 1'b1;
                    grant_d = '0;
                    rr_d    = (SLOTS > 1) ? owner_q : '0;
                    state_d = S_RELEASE;
                end
            end

            S_RELEASE: begin
                idle_d  = '0;
                state_d = S_IDLE;
            end

            default: begin
                grant_d = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    assign grant         = grant_q;
    assign out_data      = out_data_q;
    assign out_valid     = out_valid_q;
    assign timeout_abort = abort_q;

`ifdef TRANSMIT_SLOT_SCHEDULER_STATS_EN
    logic                   eof_accept;
    logic [COUNT_WIDTH-1:0] frame_count_q;

    assign eof_accept = (|pop) & beat_eof;

    // Counts completed frames only; aborted or dropped frames never reach an accepted EOF.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            frame_count_q <= '0;
        end else if (eof_accept) begin
            frame_count_q <= COUNT_WIDTH'(frame_count_q + 1'b1);
        end
    end

    assign frame_count = frame_count_q;
`else
    assign frame_count = '0;
`endif

endmodule

// File: tb/tb_transmit_slot_scheduler.sv
// Scoreboard bench for transmit_slot_scheduler: per-slot frame sources, expected beat queue,
// grant-order/gap/abort bookkeeping sampled on the falling edge.
module tb_transmit_slot_scheduler;
    import transmit_scheduler_pkg::*;

    localparam int unsigned SLOTS   = 4;
    localparam int unsigned TIMEOUT = 4;
    localparam int unsigned MAXB    = 8;

    logic                             clock   = 1'b0;
    logic                             reset_n = 1'b1;
    logic [SLOTS-1:0]                 request;
    logic [SLOTS-1:0][BEAT_WIDTH-1:0] data;
    logic [SLOTS-1:0]                 data_valid;
    logic [SLOTS-1:0]                 grant;
    logic [SLOTS-1:0]                 pop;
    logic [BEAT_WIDTH-1:0]            out_data;
    logic                             out_valid;
    logic                             out_ready;
    logic                             timeout_abort;
    logic [COUNT_WIDTH-1:0]           frame_count;

    always #5 clock = ~clock;

    transmit_slot_scheduler #(
        .SLOTS          (SLOTS),
        .TIMEOUT_CYCLES (TIMEOUT)
    ) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .request       (request),
        .data          (data),
        .data_valid    (data_valid),
        .grant         (grant),
        .pop           (pop),
        .out_data      (out_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .timeout_abort (timeout_abort),
        .frame_count   (frame_count)
    );

    int tests_run    = 0;
    int tests_failed = 0;

    logic [BEAT_WIDTH-1:0] src_beats [SLOTS][MAXB];
    int                    src_len [SLOTS];
    int                    src_ptr [SLOTS];
    int                    src_lim [SLOTS];
    logic [SLOTS-1:0]      req_en;
    logic [SLOTS-1:0]      stall;

    logic [BEAT_WIDTH-1:0] exp_q [$];
    int                    exp_frames;

    int                    abort_cycles;
    int                    grant_cycles [SLOTS];
    int                    grant_log [$];
    int                    gap_log [$];
    logic [SLOTS-1:0]      prev_grant;
    int                    zero_run;
    bit                    seen_grant;
    logic [SLOTS-1:0]      last_pop;
    logic [BEAT_WIDTH-1:0] last_out_data;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int slot_of(input logic [SLOTS-1:0] onehot);
        for (int i = 0; i < int'(SLOTS); i++) begin
            if (onehot[i]) return i;
        end
        return -1;
    endfunction

    function automatic logic [31:0] order_code();
        logic [31:0] code = '0;
        foreach (grant_log[j]) code = (code << 4) | 32'(grant_log[j] + 1);
        return code;
    endfunction

    function automatic logic [31:0] exp_count();
`ifdef TRANSMIT_SLOT_SCHEDULER_STATS_EN
        return 32'(exp_frames & 16'hFFFF);
`else
        return 32'h0;
`endif
    endfunction

    function automatic bit quiet();
        return (request == '0) && (exp_q.size() == 0) && !out_valid && (grant == '0);
    endfunction

    task automatic drive_sources();
        for (int i = 0; i < int'(SLOTS); i++) begin
            logic avail;
            avail         = req_en[i] && (src_ptr[i] < src_lim[i]);
            request[i]    = avail;
            data_valid[i] = avail && !stall[i];
            data[i]       = (src_ptr[i] < src_len[i]) ? src_beats[i][src_ptr[i]] : '0;
        end
    endtask

    task automatic add_frame(input int slot, input int n, input logic [7:0] base,
                             input logic [7:0] last_byte);
        for (int j = 0; j < n; j++) begin
            src_beats[slot][src_len[slot]] = (j == n - 1) ? {1'b1, last_byte}
                                                          : {1'b0, 8'(base + 8'(j))};
            src_len[slot]++;
        end
        src_lim[slot] = src_len[slot];
    endtask

    task automatic expect_slot(input int slot, input int from, input int cnt);
        for (int j = from; j < from + cnt; j++) begin
            exp_q.push_back(src_beats[slot][j]);
            if (src_beats[slot][j][EOF_BIT]) exp_frames++;
        end
    endtask

    task automatic clear_stats();
        abort_cycles = 0;
        for (int i = 0; i < int'(SLOTS); i++) grant_cycles[i] = 0;
        grant_log.delete();
        gap_log.delete();
        prev_grant = '0;
        zero_run   = 0;
        seen_grant = 0;
    endtask

    task automatic monitor();
        check_eq("pop_ungranted", 32'(pop & ~grant), 32'h0);
        if (timeout_abort) abort_cycles++;
        for (int i = 0; i < int'(SLOTS); i++) if (grant[i]) grant_cycles[i]++;
        if (grant != '0 && prev_grant == '0) begin
            grant_log.push_back(slot_of(grant));
            if (seen_grant) gap_log.push_back(zero_run);
            seen_grant = 1;
            zero_run   = 0;
        end else if (grant == '0 && seen_grant) begin
            zero_run++;
        end
        prev_grant = grant;
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) check_eq("out_extra_beat", 32'(out_valid), 32'h0);
            else                   check_eq("out_data", 32'(out_data), 32'(exp_q.pop_front()));
        end
    endtask

    task automatic tick();
        logic [SLOTS-1:0] pops;
        @(negedge clock);
        pops          = pop;
        last_pop      = pop;
        last_out_data = out_data;
        monitor();
        @(posedge clock);
        #1;
        for (int i = 0; i < int'(SLOTS); i++) if (pops[i]) src_ptr[i]++;
        drive_sources();
    endtask

    task automatic apply_reset();
        reset_n = 1'b0;
        #2;
        check_eq("rst_grant", 32'(grant), 32'h0);
        check_eq("rst_out_valid", 32'(out_valid), 32'h0);
        check_eq("rst_out_data", 32'(out_data), 32'h0);
        check_eq("rst_abort", 32'(timeout_abort), 32'h0);
        check_eq("rst_frame_count", 32'(frame_count), 32'h0);
        check_eq("rst_pop", 32'(pop), 32'h0);
        for (int i = 0; i < int'(SLOTS); i++) begin
            src_len[i] = 0;
            src_ptr[i] = 0;
            src_lim[i] = 0;
        end
        req_en     = '0;
        stall      = '0;
        out_ready  = 1'b1;
        exp_q.delete();
        exp_frames = 0;
        drive_sources();
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock);
        #1;
        clear_stats();
    endtask

    task automatic drain(input string tag, input int budget);
        int n = 0;
        while (!quiet() && n < budget) begin
            tick();
            n++;
        end
        check_eq({tag, "_drained"}, 32'(quiet()), 32'h1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        request    = '0;
        data       = '0;
        data_valid = '0;
        out_ready  = 1'b1;
        #1;
        apply_reset();

        // Reset mid-frame drops the frame; slot 0 is searched first afterwards.
        add_frame(1, 5, 8'h10, 8'h15);
        req_en[1] = 1'b1;
        expect_slot(1, 0, 5);
        drive_sources();
        n = 0;
        while (src_ptr[1] < 2 && n < 20) begin tick(); n++; end
        check_eq("t1_midframe", 32'(src_ptr[1] >= 2), 32'h1);
        apply_reset();
        add_frame(0, 1, 8'h00, 8'h0E);
        add_frame(3, 1, 8'h00, 8'h3E);
        req_en[0] = 1'b1;
        req_en[3] = 1'b1;
        expect_slot(0, 0, 1);
        expect_slot(3, 0, 1);
        drive_sources();
        drain("t1", 40);
        check_eq("t1_order", order_code(), 32'h14);

        // Two 3-beat frames, 2-cycle gap between grants.
        apply_reset();
        add_frame(0, 3, 8'h01, 8'hAA);
        add_frame(2, 3, 8'h21, 8'hAA);
        req_en[0] = 1'b1;
        req_en[2] = 1'b1;
        expect_slot(0, 0, 3);
        expect_slot(2, 0, 3);
        drive_sources();
        drain("t2", 60);
        check_eq("t2_order", order_code(), 32'h13);
        check_eq("t2_gap", 32'(gap_log.size() > 0 ? gap_log[0] : -1), 32'd2);
        check_eq("t2_grant_cycles", 32'(grant_cycles[0]), 32'd3);
        check_eq("t2_frame_count", 32'(frame_count), exp_count());

        // All slots, two 1-beat frames each: strict rotation.
        apply_reset();
        for (int i = 0; i < int'(SLOTS); i++) begin
            add_frame(i, 1, 8'h00, 8'(i * 16 + 1));
            add_frame(i, 1, 8'h00, 8'(i * 16 + 2));
            req_en[i] = 1'b1;
        end
        for (int f = 0; f < 2; f++)
            for (int i = 0; i < int'(SLOTS); i++) expect_slot(i, f, 1);
        drive_sources();
        drain("t3", 120);
        check_eq("t3_order", order_code(), 32'h12341234);
        check_eq("t3_gap_count", 32'(gap_log.size()), 32'd7);
        foreach (gap_log[j]) check_eq("t3_gap", 32'(gap_log[j]), 32'd2);
        check_eq("t3_frame_count", 32'(frame_count), exp_count());

        // Backpressure mid-frame: no pops, output held, no watchdog.
        apply_reset();
        add_frame(3, 6, 8'h30, 8'h3F);
        req_en[3] = 1'b1;
        expect_slot(3, 0, 6);
        drive_sources();
        n = 0;
        while (src_ptr[3] < 2 && n < 20) begin tick(); n++; end
        check_eq("t4_started", 32'(src_ptr[3] >= 2), 32'h1);
        out_ready = 1'b0;
        for (int c = 0; c < 10; c++) begin
            tick();
            check_eq("t4_pop_held", 32'(last_pop), 32'h0);
            check_eq("t4_data_held", 32'(last_out_data),
                     32'(src_beats[3][src_ptr[3] > 0 ? src_ptr[3] - 1 : 0]));
        end
        out_ready = 1'b1;
        drain("t4", 40);
        check_eq("t4_abort", 32'(abort_cycles), 32'd0);
        check_eq("t4_frame_count", 32'(frame_count), exp_count());

        // Stalled owner: watchdog aborts once after 4 idle cycles, grant moves on.
        apply_reset();
        add_frame(1, 1, 8'h00, 8'h51);
        add_frame(2, 1, 8'h00, 8'h61);
        stall[1]  = 1'b1;
        req_en[1] = 1'b1;
        req_en[2] = 1'b1;
        expect_slot(2, 0, 1);
        drive_sources();
        n = 0;
        while (abort_cycles == 0 && n < 30) begin tick(); n++; end
        req_en[1] = 1'b0;
        drive_sources();
        drain("t5", 40);
        check_eq("t5_abort_pulses", 32'(abort_cycles), 32'd1);
        check_eq("t5_grant_cycles", 32'(grant_cycles[1]), 32'd4);
        check_eq("t5_order", order_code(), 32'h23);
        check_eq("t5_frame_count", 32'(frame_count), exp_count());

        // Request dropped after 2 beats: quiet release, next requester follows.
        apply_reset();
        add_frame(0, 4, 8'h71, 8'h74);
        src_lim[0] = 2;
        add_frame(1, 1, 8'h00, 8'h81);
        req_en[0] = 1'b1;
        req_en[1] = 1'b1;
        expect_slot(0, 0, 2);
        expect_slot(1, 0, 1);
        drive_sources();
        drain("t6", 40);
        check_eq("t6_order", order_code(), 32'h12);
        check_eq("t6_grant_cycles", 32'(grant_cycles[0]), 32'd3);
        check_eq("t6_gap", 32'(gap_log.size() > 0 ? gap_log[0] : -1), 32'd2);
        check_eq("t6_abort", 32'(abort_cycles), 32'd0);
        check_eq("t6_frame_count", 32'(frame_count), exp_count());

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
